// File: rtl/uart_cmd_frame_gen.sv
// Command serializer: turns one register-file/ALU command into back-to-back UART frames
// (opcode first, then operands), LSB-first, optional parity, programmable bit period.
module uart_cmd_frame_gen #(
   parameter int unsigned GAP_BITS = 10
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] CMD_TYPE,
   input  logic [7:0] ARG0,
   input  logic [7:0] ARG1,
   input  logic [7:0] ARG2,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic [5:0] PRESCALE,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   output logic       TX_OUT,
   output logic       BUSY,
   output logic       FRAME_DONE,
   output logic       CMD_DONE
);

   localparam int unsigned GAP_MAX = GAP_BITS * 32'd63;
   localparam int          GW      = (GAP_MAX < 32'd2) ? 1 : $clog2(GAP_MAX + 32'd1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      GAP    = 3'd5
   } state_t;

   function automatic logic parity_f(input logic [7:0] data, input logic odd);
      parity_f = (^data) ^ odd;
   endfunction

   function automatic logic [7:0] opcode_f(input logic [1:0] ty);
      case (ty)
         2'b00:   opcode_f = 8'hAA;
         2'b01:   opcode_f = 8'hBB;
         2'b10:   opcode_f = 8'hCC;
         2'b11:   opcode_f = 8'hDD;
         default: opcode_f = 8'hAA;
      endcase
   endfunction

   function automatic logic [1:0] last_frame_f(input logic [1:0] ty);
      case (ty)
         2'b00:   last_frame_f = 2'd2;
         2'b01:   last_frame_f = 2'd1;
         2'b10:   last_frame_f = 2'd3;
         2'b11:   last_frame_f = 2'd1;
         default: last_frame_f = 2'd1;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      frame_q, frame_d;
   logic [GW-1:0]   gap_q, gap_d;

   logic [1:0]      type_q;
   logic [7:0]      a0_q, a1_q, a2_q;
   logic            par_en_q, par_typ_q;
   logic [5:0]      pre_q;

   logic            tx_q, tx_d;
   logic            ready_q, ready_d;
   logic            busy_q;
   logic            fd_pend_q, fd_q;
   logic            cd_pend_q, cd_q;

   logic            accept_s;
   logic            tick_s;
   logic            stop_end_s;
   logic            cmd_end_s;
   logic            is_alu_s;
   logic [7:0]      cur_byte_s;
   logic [GW-1:0]   gap_lim_s;

   // ready_q is only ever 1 while the FSM sits in IDLE, so it doubles as the accept qualifier
   assign accept_s  = CMD_VALID & ready_q;
   assign tick_s    = (cnt_q == (pre_q - 6'd1));
   assign is_alu_s  = type_q[1];
   assign gap_lim_s = GW'(GAP_BITS * {26'd0, pre_q});

   // Byte currently being serialized, selected by frame index
   always_comb begin
      case (frame_q)
         2'd0:    cur_byte_s = opcode_f(type_q);
         2'd1:    cur_byte_s = a0_q;
         2'd2:    cur_byte_s = a1_q;
         2'd3:    cur_byte_s = a2_q;
         default: cur_byte_s = 8'h00;
      endcase
   end

   // FSM state register and counters
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         bit_q   <= 3'd0;
         frame_q <= 2'd0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         gap_q   <= gap_d;
      end
   end

   // Command capture at acceptance; inputs are ignored for the rest of the command
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         type_q    <= 2'd0;
         a0_q      <= 8'h00;
         a1_q      <= 8'h00;
         a2_q      <= 8'h00;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         pre_q     <= 6'd1;
      end else if (accept_s) begin
         type_q    <= CMD_TYPE;
         a0_q      <= ARG0;
         a1_q      <= ARG1;
         a2_q      <= ARG2;
         par_en_q  <= PAR_EN;
         par_typ_q <= PAR_TYP;
         pre_q     <= (PRESCALE == 6'd0) ? 6'd1 : PRESCALE;
      end else begin
         type_q    <= type_q;
         a0_q      <= a0_q;
         a1_q      <= a1_q;
         a2_q      <= a2_q;
         par_en_q  <= par_en_q;
         par_typ_q <= par_typ_q;
         pre_q     <= pre_q;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      frame_d    = frame_q;
      gap_d      = gap_q;
      stop_end_s = 1'b0;
      cmd_end_s  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d   = 6'd0;
            bit_d   = 3'd0;
            frame_d = 2'd0;
            gap_d   = '0;
            if (accept_s) state_d = START;
            else          state_d = IDLE;
         end
         START: begin
            if (tick_s) begin
               cnt_d   = 6'd0;
               state_d = DATA;
            end else begin
               cnt_d   = cnt_q + 6'd1;
            end
         end
         DATA: begin
            if (tick_s) begin
               cnt_d = 6'd0;
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
               else               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         PARITY: begin
            if (tick_s) begin
               cnt_d   = 6'd0;
               state_d = STOP;
            end else begin
               cnt_d   = cnt_q + 6'd1;
            end
         end
         STOP: begin
            if (tick_s) begin
               cnt_d      = 6'd0;
               stop_end_s = 1'b1;
               if (frame_q != last_frame_f(type_q)) begin
                  frame_d = frame_q + 2'd1;
                  state_d = START;
               end else if (is_alu_s && (GAP_BITS != 32'd0)) begin
                  gap_d   = '0;
                  state_d = GAP;
               end else begin
                  cmd_end_s = 1'b1;
                  state_d   = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         GAP: begin
            if (gap_q == (gap_lim_s - GW'(1))) begin
               cmd_end_s = 1'b1;
               state_d   = IDLE;
            end else begin
               gap_d     = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode; registered below, so the line lags the FSM by exactly one cycle
   always_comb begin
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte_s[bit_q];
         PARITY:  tx_d = parity_f(cur_byte_s, par_typ_q);
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
      if (state_q == IDLE) ready_d = ~accept_s;
      else                 ready_d = 1'b0;
   end

   // Registered outputs; done pulses go through a pending stage to land one cycle after the stop bit
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         fd_pend_q <= 1'b0;
         fd_q      <= 1'b0;
         cd_pend_q <= 1'b0;
         cd_q      <= 1'b0;
      end else begin
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= ~ready_d;
         fd_pend_q <= stop_end_s;
         fd_q      <= fd_pend_q;
         cd_pend_q <= cmd_end_s;
         cd_q      <= cd_pend_q;
      end
   end

   assign TX_OUT     = tx_q;
   assign CMD_READY  = ready_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = fd_q;
   assign CMD_DONE   = cd_q;

endmodule

// File: tb/tb_uart_cmd_frame_gen.sv
// Directed bench for uart_cmd_frame_gen: table of commands with hand-computed frames,
// parity bits and CMD_DONE latency, plus held-valid and mid-frame reset sequences.
module tb_uart_cmd_frame_gen;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] CMD_TYPE;
   logic [7:0] ARG0, ARG1, ARG2;
   logic       PAR_EN, PAR_TYP;
   logic [5:0] PRESCALE;
   logic       CMD_VALID;
   logic       CMD_READY, TX_OUT, BUSY, FRAME_DONE, CMD_DONE;

   int n_total = 0;
   int n_pass  = 0;

   uart_cmd_frame_gen #(.GAP_BITS(10)) dut (
      .CLK(CLK), .RST(RST), .CMD_TYPE(CMD_TYPE),
      .ARG0(ARG0), .ARG1(ARG1), .ARG2(ARG2),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .TX_OUT(TX_OUT),
      .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .CMD_DONE(CMD_DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]      ty;
      logic [7:0]      a0, a1, a2;
      logic            pe, pt;
      logic [5:0]      pre;
      int              p;
      int              nfr;
      logic [3:0][7:0] by;
      logic [3:0]      pb;
      int              gap;
      int              lat;
   } vec_t;

   vec_t vt[6];

   function automatic vec_t mk(input logic [1:0] ty, input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic pe, input logic pt,
                               input logic [5:0] pre, input int p, input int nfr,
                               input logic [31:0] by, input logic [3:0] pb,
                               input int gap, input int lat);
      vec_t v;
      v.ty = ty; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.pe = pe; v.pt = pt;
      v.pre = pre; v.p = p; v.nfr = nfr; v.by = by; v.pb = pb; v.gap = gap; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic wait_ready(input int max_cycles);
      int n;
      n = 0;
      while (CMD_READY !== 1'b1 && n < max_cycles) begin
         @(negedge CLK);
         n++;
      end
      if (CMD_READY !== 1'b1) check("ready_timeout", 0, 1);
   endtask

   task automatic drive(input vec_t v);
      CMD_TYPE = v.ty; ARG0 = v.a0; ARG1 = v.a1; ARG2 = v.a2;
      PAR_EN = v.pe; PAR_TYP = v.pt; PRESCALE = v.pre;
   endtask

   task automatic run_cmd(input int idx, input bit hold);
      vec_t v;
      bit   s[0:43];
      int   nb, mism, bad_j, fdc, cdc, done_j;
      v  = vt[idx];
      nb = 0;
      for (int f = 0; f < v.nfr; f++) begin
         s[nb] = 1'b0; nb++;
         for (int b = 0; b < 8; b++) begin s[nb] = v.by[f][b]; nb++; end
         if (v.pe) begin s[nb] = v.pb[f]; nb++; end
         s[nb] = 1'b1; nb++;
      end
      wait_ready(6000);
      drive(v);
      CMD_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("v%0d_ready_after_accept", idx), CMD_READY, 0);
      if (!hold) CMD_VALID = 1'b0;
      mism = 0; bad_j = -1; fdc = 0; cdc = 0; done_j = -1;
      for (int j = 1; j <= v.lat + 2; j++) begin
         @(negedge CLK);
         if (j == 3) begin
            CMD_TYPE = ~v.ty; ARG0 = ~v.a0; ARG1 = ~v.a1; ARG2 = ~v.a2;
            PAR_EN = ~v.pe; PAR_TYP = ~v.pt; PRESCALE = v.pre + 6'd5;
         end
         if (j <= nb * v.p) begin
            if (TX_OUT !== s[(j-1)/v.p]) begin mism++; if (bad_j < 0) bad_j = j; end
         end else if (j < v.lat) begin
            if (TX_OUT !== 1'b1) begin mism++; if (bad_j < 0) bad_j = j; end
         end
         if (j <= v.lat && FRAME_DONE === 1'b1) fdc++;
         if (CMD_DONE === 1'b1) begin cdc++; if (done_j < 0) done_j = j; end
         if (j == v.lat / 2) check($sformatf("v%0d_busy_mid", idx), BUSY, 1);
         if (j == v.lat - 1) check($sformatf("v%0d_ready_before_done", idx), CMD_READY, 0);
         if (j == v.lat)     check($sformatf("v%0d_ready_at_done", idx), CMD_READY, 1);
         if (hold && j == v.lat + 1) check("hold_reaccept_ready", CMD_READY, 0);
         if (hold && j == v.lat + 2) check("hold_reaccept_start", TX_OUT, 0);
      end
      check($sformatf("v%0d_line_bits", idx), mism, 0);
      if (mism != 0) $display("  first bad cycle after accept: %0d", bad_j);
      check($sformatf("v%0d_frame_done_count", idx), fdc, v.nfr);
      check($sformatf("v%0d_cmd_done_latency", idx), done_j, v.lat);
      check($sformatf("v%0d_cmd_done_pulses", idx), cdc, 1);
   endtask

   initial begin
      int cd;
      //              ty     a0     a1     a2     pe    pt    pre   p  nfr  bytes {f3,f2,f1,f0}  par   gap lat
      vt[0] = mk(2'b00, 8'h05, 8'hAB, 8'h00, 1'b0, 1'b0, 6'd8, 8, 3, 32'h00AB05AA, 4'b0000, 0, 241);
      vt[1] = mk(2'b01, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 6'd8, 8, 2, 32'h000002BB, 4'b0010, 0, 177);
      vt[2] = mk(2'b10, 8'h08, 8'h04, 8'h00, 1'b0, 1'b0, 6'd8, 8, 4, 32'h000408CC, 4'b0000, 80, 401);
      vt[3] = mk(2'b11, 8'h0A, 8'h00, 8'h00, 1'b1, 1'b1, 6'd8, 8, 2, 32'h00000ADD, 4'b0011, 80, 257);
      vt[4] = mk(2'b00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 6'd0, 1, 3, 32'h00FF00AA, 4'b0000, 0, 31);
      vt[5] = mk(2'b01, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 6'd3, 3, 2, 32'h000080BB, 4'b0001, 0, 67);

      RST = 1'b1; CMD_VALID = 1'b0;
      CMD_TYPE = 2'b00; ARG0 = 8'h00; ARG1 = 8'h00; ARG2 = 8'h00;
      PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd8;
      repeat (3) @(negedge CLK);
      check("reset_tx", TX_OUT, 1);
      check("reset_ready", CMD_READY, 1);
      check("reset_busy", BUSY, 0);
      check("reset_frame_done", FRAME_DONE, 0);
      check("reset_cmd_done", CMD_DONE, 0);
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 6; i++) run_cmd(i, 1'b0);

      // CMD_VALID held high: re-accept only once CMD_READY is back
      run_cmd(0, 1'b1);
      CMD_VALID = 1'b0;
      wait_ready(6000);
      @(negedge CLK);

      // Reset during a data bit of the second frame
      wait_ready(6000);
      drive(vt[0]);
      CMD_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      CMD_VALID = 1'b0;
      repeat (99) @(negedge CLK);
      RST = 1'b1;
      #1;
      check("rst_mid_tx", TX_OUT, 1);
      check("rst_mid_ready", CMD_READY, 1);
      check("rst_mid_busy", BUSY, 0);
      @(negedge CLK);
      RST = 1'b0;
      cd = 0;
      repeat (300) begin
         @(negedge CLK);
         if (CMD_DONE === 1'b1) cd++;
      end
      check("rst_mid_no_cmd_done", cd, 0);
      check("rst_mid_line_idle", TX_OUT, 1);

      run_cmd(0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
